// File: rtl/surf_cout_autotrain.sv
// Autonomous COUT lane link training: IDELAY eye scan, centring on the widest
// error-free window, then bitslip alignment against the training word.
module surf_cout_autotrain #(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          CAPTURE_WAIT   = 8,
    parameter int          RST_CYCLES     = 4,
    parameter int          MIN_EYE        = 4,
    parameter int          MAX_BITSLIP    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] cout_data_i,
    input  logic        cout_biterr_i,
    output logic [5:0]  idelay_value_o,
    output logic        idelay_load_o,
    output logic        iserdes_rst_o,
    output logic        bitslip_o,
    output logic        cout_capture_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [5:0]  eye_start_o,
    output logic [6:0]  eye_width_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_LOAD, S_SETTLE, S_CAP, S_EVAL, S_CENTER,
        S_CSETTLE, S_ACAP, S_AEVAL, S_SLIP, S_DONE, S_FAIL
    } state_t;

    localparam logic [7:0] LP_RST_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LP_CAP_LAST    = 8'(CAPTURE_WAIT);
    localparam logic [6:0] LP_MIN_EYE     = 7'(MIN_EYE);
    localparam logic [7:0] LP_MAX_SLIP    = 8'(MAX_BITSLIP);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [5:0] r_tap;
    logic [5:0] r_run_start;
    logic [6:0] r_run_len;
    logic [5:0] r_best_start;
    logic [6:0] r_best_len;
    logic [7:0] r_slips;
    logic [5:0] r_idelay;
    logic [5:0] r_eye_start;
    logic [6:0] r_eye_width;

    logic       w_good;
    logic [6:0] w_run_len_nx;
    logic [5:0] w_run_start_nx;
    logic [6:0] w_close_len;
    logic       w_close;
    logic       w_eye_ok;
    logic [5:0] w_centre;
    logic       w_match;
    logic       w_start_ok;

    assign w_good         = !cout_biterr_i;
    assign w_run_len_nx   = w_good ? r_run_len + 7'd1 : 7'd0;
    assign w_run_start_nx = (w_good && r_run_len == 7'd0) ? r_tap : r_run_start;
    // A run closes on a bad tap (previous run) or at tap 63 (run including it).
    assign w_close_len    = w_good ? w_run_len_nx : r_run_len;
    assign w_close        = !w_good || (r_tap == 6'd63);
    assign w_eye_ok       = (r_best_len >= LP_MIN_EYE);
    assign w_centre       = r_best_start + r_best_len[6:1];
    assign w_match        = !cout_biterr_i && (cout_data_i == TRAIN_SEQUENCE);
    assign w_start_ok     = start_i &&
                            (r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: if (start_i) w_next = S_RST;
            S_RST:     if (r_cnt == LP_RST_LAST) w_next = S_LOAD;
            S_LOAD:    w_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == LP_SETTLE_LAST) w_next = S_CAP;
            S_CAP:     if (r_cnt == LP_CAP_LAST) w_next = S_EVAL;
            S_EVAL:    w_next = (r_tap == 6'd63) ? S_CENTER : S_LOAD;
            S_CENTER:  w_next = w_eye_ok ? S_CSETTLE : S_FAIL;
            S_CSETTLE: if (r_cnt == LP_SETTLE_LAST) w_next = S_ACAP;
            S_ACAP:    if (r_cnt == LP_CAP_LAST) w_next = S_AEVAL;
            S_AEVAL: begin
                if (w_match)                   w_next = S_DONE;
                else if (r_slips == LP_MAX_SLIP) w_next = S_FAIL;
                else                           w_next = S_SLIP;
            end
            S_SLIP:    if (r_cnt == LP_CAP_LAST) w_next = S_ACAP;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        idelay_load_o  = (r_state == S_LOAD) || (r_state == S_CENTER && w_eye_ok);
        iserdes_rst_o  = (r_state == S_RST);
        cout_capture_o = (r_state == S_CAP || r_state == S_ACAP) && (r_cnt == 8'd0);
        bitslip_o      = (r_state == S_SLIP) && (r_cnt == 8'd0);
        busy_o         = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);
        done_o         = (r_state == S_DONE);
        fail_o         = (r_state == S_FAIL);
        eye_start_o    = r_eye_start;
        eye_width_o    = r_eye_width;
        idelay_value_o = r_idelay;
        if (r_state == S_LOAD)
            idelay_value_o = r_tap;
        else if (r_state == S_CENTER && w_eye_ok)
            idelay_value_o = w_centre;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tap        <= 6'd0;
            r_run_start  <= 6'd0;
            r_run_len    <= 7'd0;
            r_best_start <= 6'd0;
            r_best_len   <= 7'd0;
            r_slips      <= 8'd0;
            r_idelay     <= 6'd0;
            r_eye_start  <= 6'd0;
            r_eye_width  <= 7'd0;
        end else begin
            if (w_start_ok) begin
                r_tap        <= 6'd0;
                r_run_start  <= 6'd0;
                r_run_len    <= 7'd0;
                r_best_start <= 6'd0;
                r_best_len   <= 7'd0;
                r_slips      <= 8'd0;
                r_eye_start  <= 6'd0;
                r_eye_width  <= 7'd0;
            end
            if (r_state == S_LOAD)
                r_idelay <= r_tap;
            if (r_state == S_EVAL) begin
                r_run_len   <= w_run_len_nx;
                r_run_start <= w_run_start_nx;
                // Strictly longer only: ties keep the earliest window.
                if (w_close && w_close_len > r_best_len) begin
                    r_best_len   <= w_close_len;
                    r_best_start <= w_run_start_nx;
                end
                if (r_tap != 6'd63)
                    r_tap <= r_tap + 6'd1;
            end
            if (r_state == S_CENTER && w_eye_ok) begin
                r_idelay    <= w_centre;
                r_eye_start <= r_best_start;
                r_eye_width <= r_best_len;
            end
            if (r_state == S_SLIP && r_cnt == 8'd0)
                r_slips <= r_slips + 8'd1;
        end
    end

endmodule

// File: tb/tb_surf_cout_autotrain.sv
// Bench for surf_cout_autotrain: a lane model answers captures from a tap mask
// and a required slip count; whole training runs are scored against a model.
module tb_surf_cout_autotrain;

    localparam logic [31:0] TRAIN = 32'hA55A6996;

    typedef struct packed {
        logic       done;
        logic       fail;
        logic [5:0] eye_start;
        logic [6:0] eye_width;
        logic [5:0] idelay;
        logic [7:0] slips;
        logic [7:0] rsts;
        logic [7:0] loads;
        logic [5:0] first_load;
        logic [7:0] overlap;
    } res_t;
    localparam int W = $bits(res_t);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cout_data = 32'd0;
    logic        cout_biterr = 1'b1;
    logic [5:0]  idelay_value;
    logic        idelay_load, iserdes_rst, bitslip, cout_capture;
    logic        busy, done, fail;
    logic [5:0]  eye_start;
    logic [6:0]  eye_width;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [63:0] g_mask = 64'd0;
    int          g_need = 0;

    surf_cout_autotrain dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start_i       (start),
        .cout_data_i   (cout_data),
        .cout_biterr_i (cout_biterr),
        .idelay_value_o(idelay_value),
        .idelay_load_o (idelay_load),
        .iserdes_rst_o (iserdes_rst),
        .bitslip_o     (bitslip),
        .cout_capture_o(cout_capture),
        .busy_o        (busy),
        .done_o        (done),
        .fail_o        (fail),
        .eye_start_o   (eye_start),
        .eye_width_o   (eye_width)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Lane model: the loaded tap decides the bit-error flag; the word aligns
    // once enough bitslips have arrived since the last ISERDES reset.
    int lane_tap = 0;
    int lane_slips = 0;
    always @(negedge clk) begin
        if (rst) begin
            lane_tap = 0;
            lane_slips = 0;
        end else begin
            if (idelay_load) lane_tap = int'(idelay_value);
            if (iserdes_rst) lane_slips = 0;
            if (bitslip) lane_slips++;
        end
        cout_biterr = !g_mask[lane_tap];
        cout_data = (lane_slips >= g_need) ? TRAIN : (TRAIN ^ ($urandom | 32'd1));
    end

    // Reference: longest run of ones found by brute force over every start.
    function automatic res_t model(input logic [63:0] m, input int need);
        res_t r;
        int best_len, best_start, len;
        logic ok;
        best_len = 0;
        best_start = 0;
        for (int s = 0; s < 64; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
                len = 0;
                while (s + len < 64 && m[s+len]) len++;
                if (len > best_len) begin
                    best_len = len;
                    best_start = s;
                end
            end
        end
        ok = (best_len >= 4);
        r = '0;
        r.done       = ok && (need <= 8);
        r.fail       = !r.done;
        r.eye_start  = ok ? 6'(best_start) : 6'd0;
        r.eye_width  = ok ? 7'(best_len) : 7'd0;
        r.idelay     = ok ? 6'((best_start + best_len / 2) % 64) : 6'd63;
        r.slips      = ok ? 8'((need <= 8) ? need : 8) : 8'd0;
        r.rsts       = 8'd4;
        r.loads      = ok ? 8'd65 : 8'd64;
        r.first_load = 6'd0;
        r.overlap    = 8'd0;
        return r;
    endfunction

    function automatic logic [63:0] win(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // monitor / scoreboard
    int   m_slips = 0, m_rsts = 0, m_loads = 0, m_overlap = 0;
    int   m_first = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            m_slips = 0; m_rsts = 0; m_loads = 0; m_overlap = 0; m_first = 0;
            prev_busy = 1'b0;
        end else begin
            if (idelay_load) begin
                if (m_loads == 0) m_first = int'(idelay_value);
                m_loads++;
            end
            if (iserdes_rst) m_rsts++;
            if (bitslip) m_slips++;
            if ($countones({idelay_load, bitslip, cout_capture, iserdes_rst}) > 1) m_overlap++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    e = res_t'(exp_q.pop_front());
                    chk("done", int'(done), int'(e.done));
                    chk("fail", int'(fail), int'(e.fail));
                    chk("eye_start", int'(eye_start), int'(e.eye_start));
                    chk("eye_width", int'(eye_width), int'(e.eye_width));
                    chk("idelay_final", int'(idelay_value), int'(e.idelay));
                    chk("bitslips", m_slips, int'(e.slips));
                    chk("iserdes_rst_cycles", m_rsts, int'(e.rsts));
                    chk("idelay_loads", m_loads, int'(e.loads));
                    chk("first_tap", m_first, int'(e.first_load));
                    chk("strobe_overlap", m_overlap, int'(e.overlap));
                end
                m_slips = 0; m_rsts = 0; m_loads = 0; m_overlap = 0; m_first = 0;
            end
            prev_busy = busy;
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, int'({idelay_value, idelay_load, iserdes_rst, bitslip, cout_capture,
                        busy, done, fail, eye_start, eye_width}), 0);
    endtask

    task automatic run_case(input logic [63:0] m, input int need, input bit poke);
        int n;
        g_mask = m;
        g_need = need;
        exp_q.push_back(W'(model(m, need)));
        pulse_start();
        if (poke) begin
            repeat (300) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("run_timeout", n, 0);
            exp_q.delete();
            @(posedge clk); #1 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        logic [63:0] m;
        #3 check_outputs_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_case(win(20, 35), 0, 1'b0);
        run_case(win(5, 9) | win(40, 44), 0, 1'b0);
        run_case({64{1'b1}}, 0, 1'b0);
        run_case(win(60, 63), 0, 1'b0);
        run_case(win(10, 12), 0, 1'b0);
        run_case(win(20, 35), 3, 1'b0);
        run_case(win(20, 35), 255, 1'b0);

        // Abort mid-scan while settling at tap 30, then rerun with a busy start poke.
        g_mask = win(20, 35);
        g_need = 0;
        pulse_start();
        n = 0;
        while (!(idelay_load && idelay_value == 6'd30) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_tap30", int'(n < 2000), 1);
        @(posedge clk); #3 rst = 1'b1;
        #1 check_outputs_zero("midrun_reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_case(win(20, 35), 0, 1'b1);

        for (int k = 0; k < 5; k++) begin
            m = '0;
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                int lo;
                lo = int'($urandom_range(0, 63));
                m |= win(lo, (lo + int'($urandom_range(0, 18)) > 63) ? 63 : lo + int'($urandom_range(0, 18)));
            end
            if ($urandom_range(0, 3) == 0) m ^= {$urandom, $urandom} & {$urandom, $urandom};
            run_case(m, ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 10)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
